seq_divider: RTL and testbench

//  Parametrised multi-cycle integer divider; successor to the fixed 24-bit divider.
//  - Generic width.
//  - Signed or unsigned operation, selected per operation.
//  - Start/done handshake; remainder output; divide-by-zero flag.
//  - Non-restoring, one quotient bit per enabled clock.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider_addsub.sv | 14 +
 rtl/seq_divider.sv | 168 ++++++++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and helpers for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Width of a down-counter that must hold the value n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between a divider client and the divider
interface seq_divider_if #(
    parameter int C_NUM_BITS = 24
);
    logic                  start;
    logic                  signed_mode;
    logic [C_NUM_BITS-1:0] A;
    logic [C_NUM_BITS-1:0] B;
    logic                  busy;
    logic                  done;
    logic [C_NUM_BITS-1:0] Q;
    logic [C_NUM_BITS-1:0] R;
    logic                  div_by_zero;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, Q, R, div_by_zero
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, Q, R, div_by_zero
    );
endinterface

// File: rtl/seq_divider_addsub.sv
// rtl/seq_divider_addsub.sv - partial-remainder adder/subtractor shared by iteration and correction
module div_addsub_step #(
    parameter int W = 25
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] y_o
);

    // Single adder: subtraction is a + ~b + 1, so both modes share one carry chain
    assign y_o = a_i + (sub_i ? ~b_i : b_i) + {{(W-1){1'b0}}, sub_i};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle non-restoring integer divider with start/done handshake
module seq_divider
    import div_pkg::*;
#(
    parameter int C_NUM_BITS  = 24,
    parameter int C_SIGNED_EN = 1
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         E,
    seq_divider_if.slave dif
);

    localparam int N  = C_NUM_BITS;
    localparam int CW = cnt_width(C_NUM_BITS);

    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(C_NUM_BITS);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    div_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  divisor_q;     // |B|
    logic [N-1:0]  dividend_q;    // |A| shifting out, quotient bits shifting in
    logic [N:0]    prem_q;        // signed partial remainder
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic          dbz_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  rem_q;
    logic          dbz_out_q;

    logic          signed_eff;
    logic          sign_a;
    logic          sign_b;
    logic [N-1:0]  abs_a;
    logic [N-1:0]  abs_b;
    logic          b_is_zero;
    logic [N:0]    step_a;
    logic [N:0]    step_b;
    logic          step_sub;
    logic [N:0]    step_y;
    logic          q_bit;
    logic [N-1:0]  mag_rem;
    logic [N-1:0]  quo_fin;
    logic [N-1:0]  rem_fin;

    // Operand conditioning at the start edge: effective signedness, magnitudes, zero test
    always_comb begin
        signed_eff = (C_SIGNED_EN != 0) & dif.signed_mode;
        sign_a     = signed_eff & dif.A[N-1];
        sign_b     = signed_eff & dif.B[N-1];
        abs_a      = sign_a ? (~dif.A + ONE_N) : dif.A;
        abs_b      = sign_b ? (~dif.B + ONE_N) : dif.B;
        b_is_zero  = (dif.B == '0);
    end

    // Adder operand select: shifted remainder +/- divisor in ITER, plain add-back in FIX
    always_comb begin
        step_b = {1'b0, divisor_q};
        if (state_q == FIX) begin
            step_a   = prem_q;
            step_sub = 1'b0;
        end else begin
            step_a   = {prem_q[N-1:0], dividend_q[N-1]};
            step_sub = ~prem_q[N];
        end
    end

    div_addsub_step #(
        .W (N + 1)
    ) u_step (
        .a_i   (step_a),
        .b_i   (step_b),
        .sub_i (step_sub),
        .y_o   (step_y)
    );

    // Final sign fix-up; divide-by-zero returns all-ones and the original dividend
    always_comb begin
        q_bit   = ~step_y[N];
        mag_rem = prem_q[N] ? step_y[N-1:0] : prem_q[N-1:0];
        if (dbz_q) begin
            quo_fin = '1;
            rem_fin = neg_rem_q ? (~dividend_q + ONE_N) : dividend_q;
        end else begin
            quo_fin = neg_quo_q ? (~dividend_q + ONE_N) : dividend_q;
            rem_fin = neg_rem_q ? (~mag_rem + ONE_N) : mag_rem;
        end
    end

    // Control FSM, iteration datapath and registered outputs; E=0 freezes everything
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            prem_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_out_q  <= 1'b0;
        end else if (E) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (dif.start) begin
                        divisor_q  <= abs_b;
                        dividend_q <= abs_a;
                        prem_q     <= '0;
                        neg_quo_q  <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
                        dbz_q      <= b_is_zero;
                        busy_q     <= 1'b1;
                        if (b_is_zero) begin
                            // one settle edge in FIX keeps divide-by-zero at a fixed 3-edge latency
                            state_q <= FIX;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            state_q <= ITER;
                            cnt_q   <= CNT_FULL;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ITER: begin
                    prem_q     <= step_y;
                    dividend_q <= {dividend_q[N-2:0], q_bit};
                    cnt_q      <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        quo_q     <= quo_fin;
                        rem_q     <= rem_fin;
                        dbz_out_q <= dbz_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.Q           = quo_q;
    assign dif.R           = rem_q;
    assign dif.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    localparam int N = 24;

    logic CK;
    logic RN;
    logic E;

    int n_tests;
    int n_fail;

    seq_divider_if #(.C_NUM_BITS(N)) dif ();

    seq_divider #(
        .C_NUM_BITS  (N),
        .C_SIGNED_EN (1)
    ) dut (
        .CK  (CK),
        .RN  (RN),
        .E   (E),
        .dif (dif.slave)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Issue one op from a post-edge point; returns enabled edges until done (start edge = 1)
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                          output int lat, output logic busy_ok);
        dif.A           = a;
        dif.B           = b;
        dif.signed_mode = sm;
        dif.start       = 1'b1;
        tick();
        dif.start       = 1'b0;
        dif.A           = 24'h5A5A5A;
        dif.B           = 24'h000003;
        lat             = 1;
        busy_ok         = 1'b1;
        while (!dif.done && lat < 200) begin
            if (!dif.busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    int   lat;
    logic bok;

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        RN              = 1'b0;
        E               = 1'b1;
        dif.start       = 1'b0;
        dif.signed_mode = 1'b0;
        dif.A           = '0;
        dif.B           = '0;
        repeat (3) tick();
        check("rst_outputs", {dif.busy, dif.done, dif.div_by_zero, dif.Q, dif.R}, 64'd0);
        RN = 1'b1;
        tick();

        run_op(24'd100, 24'd7, 1'b0, lat, bok);
        check("u100_7_lat", lat, 26);
        check("u100_7_busy", bok, 1);
        check("u100_7_Q", dif.Q, 24'd14);
        check("u100_7_R", dif.R, 24'd2);
        check("u100_7_dbz", dif.div_by_zero, 0);
        tick();
        check("done_one_cycle", dif.done, 0);

        run_op(24'hFFFF9C, 24'd7, 1'b1, lat, bok);
        check("sm100_7_Q", dif.Q, 24'hFFFFF2);
        check("sm100_7_R", dif.R, 24'hFFFFFE);

        run_op(24'd100, 24'hFFFFF9, 1'b1, lat, bok);
        check("s100_m7_Q", dif.Q, 24'hFFFFF2);
        check("s100_m7_R", dif.R, 24'd2);

        run_op(24'h123456, 24'h000000, 1'b0, lat, bok);
        check("dbz_lat", lat, 3);
        check("dbz_Q", dif.Q, 24'hFFFFFF);
        check("dbz_R", dif.R, 24'h123456);
        check("dbz_flag", dif.div_by_zero, 1);

        run_op(24'h800000, 24'hFFFFFF, 1'b1, lat, bok);
        check("smin_m1_Q", dif.Q, 24'h800000);
        check("smin_m1_R", dif.R, 24'h000000);
        check("smin_m1_dbz", dif.div_by_zero, 0);

        run_op(24'h800000, 24'hFFFFFF, 1'b0, lat, bok);
        check("umin_ff_Q", dif.Q, 24'h000000);
        check("umin_ff_R", dif.R, 24'h800000);
        tick();

        // Stall mid-iteration plus a start pulse while busy
        dif.A           = 24'd1000;
        dif.B           = 24'd10;
        dif.signed_mode = 1'b0;
        dif.start       = 1'b1;
        tick();
        dif.start = 1'b0;
        lat       = 1;
        repeat (3) begin tick(); lat++; end
        dif.A     = 24'd5;
        dif.B     = 24'd1;
        dif.start = 1'b1;
        tick();
        lat++;
        dif.start = 1'b0;
        check("start_busy_ignored", dif.busy, 1);
        E = 1'b0;
        repeat (5) begin tick(); lat++; end
        E = 1'b1;
        while (!dif.done && lat < 200) begin tick(); lat++; end
        check("stall_lat", lat, 31);
        check("stall_Q", dif.Q, 24'd100);
        check("stall_R", dif.R, 24'd0);
        E = 1'b0;
        repeat (3) tick();
        check("done_held_stall", dif.done, 1);
        E = 1'b1;
        tick();
        check("done_release", dif.done, 0);

        // Asynchronous reset in the middle of an op
        dif.A     = 24'd1000;
        dif.B     = 24'd3;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        repeat (8) tick();
        #3;
        RN = 1'b0;
        #1;
        check("rst_mid_op", {dif.busy, dif.done, dif.div_by_zero, dif.Q, dif.R}, 64'd0);
        #2;
        RN = 1'b1;
        tick();
        check("rst_idle", dif.busy, 0);

        run_op(24'd9, 24'd3, 1'b0, lat, bok);
        check("u9_3_lat", lat, 26);
        check("u9_3_Q", dif.Q, 24'd3);
        check("u9_3_R", dif.R, 24'd0);

        run_op(24'd50, 24'd5, 1'b0, lat, bok);
        check("b2b_lat", lat, 26);
        check("b2b_Q", dif.Q, 24'd10);
        check("b2b_R", dif.R, 24'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
